// File: rtl/arf_sequencer.sv
// arf_sequencer: control-side driver of the address register file (PC, AR, SP).
//
// Each accepted command becomes a short cycle sequence. The sequence drives
// the register file controls, runs a req/ack memory transfer addressed by the
// register file's OutD, and ends with a one-cycle response pulse.
//
// Parameters
//   WIDTH          data/address width (matches register file I/OutC/OutD)
//   TIMEOUT        max cycles to wait for MemAck in MEM; 0 disables the timeout
//   STACK_TOP      (ARF_SEQ_STACK_CHECK_EN only) SP value that faults POP/RET
//   STACK_BOTTOM   (ARF_SEQ_STACK_CHECK_EN only) SP value that faults PUSH/CALL
//
// Optional feature macro: ARF_SEQ_STACK_CHECK_EN (adds SpIn and the stack-fault check)
//
// Ports
//   Clock, Reset            rising-edge clock, synchronous active-high reset
//   CmdValid/CmdReady       command handshake (CmdReady high only in IDLE)
//   CmdOp, CmdData          command opcode and push data / jump target
//   PcIn                    register file OutC (PC), latched at accept
//   SpIn                    current SP value (stack-check build only)
//   FunSel, RegSel          register file function and active-low enables
//   OutCSel, OutDSel        register file output selects
//   ArfI                    register file load data
//   MemReq, MemWrite        memory request / direction
//   MemWData, MemRData      memory write / read data
//   MemAck                  completes the current memory request
//   RspValid, RspData       one-cycle response pulse and returned data
//   RspErr                  response error (timeout or stack fault)
module arf_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 255
`ifdef ARF_SEQ_STACK_CHECK_EN
    ,
    parameter logic [WIDTH-1:0] STACK_TOP    = 16'hFFFF,
    parameter logic [WIDTH-1:0] STACK_BOTTOM = 16'hFF00
`endif
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [2:0]       CmdOp,
    input  logic [WIDTH-1:0] CmdData,
    input  logic [WIDTH-1:0] PcIn,
`ifdef ARF_SEQ_STACK_CHECK_EN
    input  logic [WIDTH-1:0] SpIn,
`endif
    output logic [2:0]       FunSel,
    output logic [2:0]       RegSel,
    output logic [1:0]       OutCSel,
    output logic [1:0]       OutDSel,
    output logic [WIDTH-1:0] ArfI,
    output logic             MemReq,
    output logic             MemWrite,
    output logic [WIDTH-1:0] MemWData,
    input  logic [WIDTH-1:0] MemRData,
    input  logic             MemAck,
    output logic             RspValid,
    output logic [WIDTH-1:0] RspData,
    output logic             RspErr
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SP_DEC  = 3'd1,
        S_MEM     = 3'd2,
        S_INC     = 3'd3,
        S_LOAD_PC = 3'd4,
        S_RSP     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_FETCH = 3'b001,
        OP_PUSH  = 3'b010,
        OP_POP   = 3'b011,
        OP_JUMP  = 3'b100,
        OP_CALL  = 3'b101,
        OP_RET   = 3'b110,
        OP_NOP7  = 3'b111
    } op_e;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;

    localparam logic [2:0] RS_NONE = 3'b111;
    localparam logic [2:0] RS_PC   = 3'b011;
    localparam logic [2:0] RS_SP   = 3'b110;

    localparam logic [1:0] OD_PC = 2'b00;
    localparam logic [1:0] OD_SP = 2'b11;

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Control state
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Registered outputs
    logic             cmd_ready_q, cmd_ready_d;
    logic [2:0]       fun_sel_q, fun_sel_d;
    logic [2:0]       reg_sel_q, reg_sel_d;
    logic [1:0]       out_d_sel_q, out_d_sel_d;
    logic [WIDTH-1:0] arf_i_q, arf_i_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_write_q, mem_write_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             stack_fault;

    always_comb begin
        stack_fault = 1'b0;
`ifdef ARF_SEQ_STACK_CHECK_EN
        if (((CmdOp == OP_PUSH) || (CmdOp == OP_CALL)) && (SpIn == STACK_BOTTOM))
            stack_fault = 1'b1;
        if (((CmdOp == OP_POP) || (CmdOp == OP_RET)) && (SpIn == STACK_TOP))
            stack_fault = 1'b1;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (CmdValid && cmd_ready_q) begin
                    op_d    = op_e'(CmdOp);
                    data_d  = CmdData;
                    pc_d    = PcIn;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    unique case (op_e'(CmdOp))
                        OP_FETCH, OP_POP, OP_RET: state_d = S_MEM;
                        OP_PUSH, OP_CALL:         state_d = S_SP_DEC;
                        OP_JUMP:                  state_d = S_LOAD_PC;
                        default:                  state_d = S_RSP;
                    endcase
                    if (stack_fault) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end
                end
            end
            S_SP_DEC: begin
                cnt_d   = '0;
                state_d = S_MEM;
            end
            S_MEM: begin
                if (MemAck) begin
                    rdata_d = MemRData;
                    unique case (op_q)
                        OP_FETCH, OP_POP, OP_RET: state_d = S_INC;
                        OP_CALL:                  state_d = S_LOAD_PC;
                        default:                  state_d = S_RSP;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Timeout jumps straight to RSP, skipping any INC/LOAD_PC.
                    if ((TIMEOUT != 0) && (cnt_d == TIMEOUT_C)) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end
                end
            end
            S_INC:     state_d = (op_q == OP_RET) ? S_LOAD_PC : S_RSP;
            S_LOAD_PC: state_d = S_RSP;
            S_RSP:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they can be registered and still
    // line up with the state they belong to.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        fun_sel_d   = FS_DEC;
        reg_sel_d   = RS_NONE;
        out_d_sel_d = OD_PC;
        arf_i_d     = '0;
        mem_req_d   = 1'b0;
        mem_write_d = 1'b0;
        mem_wdata_d = '0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;

        unique case (state_d)
            S_SP_DEC: begin
                fun_sel_d = FS_DEC;
                reg_sel_d = RS_SP;
            end
            S_MEM: begin
                mem_req_d   = 1'b1;
                mem_write_d = (op_d == OP_PUSH) || (op_d == OP_CALL);
                out_d_sel_d = (op_d == OP_FETCH) ? OD_PC : OD_SP;
                if (op_d == OP_PUSH)
                    mem_wdata_d = data_d;
                else if (op_d == OP_CALL)
                    mem_wdata_d = pc_d;
            end
            S_INC: begin
                fun_sel_d = FS_INC;
                reg_sel_d = (op_d == OP_FETCH) ? RS_PC : RS_SP;
            end
            S_LOAD_PC: begin
                fun_sel_d = FS_LOAD;
                reg_sel_d = RS_PC;
                arf_i_d   = (op_d == OP_RET) ? rdata_d : data_d;
            end
            S_RSP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_d;
                rsp_data_d  = rdata_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            data_q      <= '0;
            pc_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            fun_sel_q   <= FS_DEC;
            reg_sel_q   <= RS_NONE;
            out_d_sel_q <= OD_PC;
            arf_i_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            pc_q        <= pc_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            fun_sel_q   <= fun_sel_d;
            reg_sel_q   <= reg_sel_d;
            out_d_sel_q <= out_d_sel_d;
            arf_i_q     <= arf_i_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign CmdReady = cmd_ready_q;
    assign FunSel   = fun_sel_q;
    assign RegSel   = reg_sel_q;
    assign OutCSel  = 2'b00;
    assign OutDSel  = out_d_sel_q;
    assign ArfI     = arf_i_q;
    assign MemReq   = mem_req_q;
    assign MemWrite = mem_write_q;
    assign MemWData = mem_wdata_q;
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign RspErr   = rsp_err_q;

endmodule

// File: tb/tb_arf_sequencer.sv
// Directed testbench for arf_sequencer (TIMEOUT overridden to 4).
module tb_arf_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        CmdValid;
    logic        CmdReady;
    logic [2:0]  CmdOp;
    logic [15:0] CmdData;
    logic [15:0] PcIn;
`ifdef ARF_SEQ_STACK_CHECK_EN
    logic [15:0] SpIn;
`endif
    logic [2:0]  FunSel;
    logic [2:0]  RegSel;
    logic [1:0]  OutCSel;
    logic [1:0]  OutDSel;
    logic [15:0] ArfI;
    logic        MemReq;
    logic        MemWrite;
    logic [15:0] MemWData;
    logic [15:0] MemRData;
    logic        MemAck;
    logic        RspValid;
    logic [15:0] RspData;
    logic        RspErr;

    int unsigned checks = 0;
    int unsigned errors = 0;

    arf_sequencer #(.WIDTH(16), .TIMEOUT(4)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .CmdOp    (CmdOp),
        .CmdData  (CmdData),
        .PcIn     (PcIn),
`ifdef ARF_SEQ_STACK_CHECK_EN
        .SpIn     (SpIn),
`endif
        .FunSel   (FunSel),
        .RegSel   (RegSel),
        .OutCSel  (OutCSel),
        .OutDSel  (OutDSel),
        .ArfI     (ArfI),
        .MemReq   (MemReq),
        .MemWrite (MemWrite),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .MemAck   (MemAck),
        .RspValid (RspValid),
        .RspData  (RspData),
        .RspErr   (RspErr)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_ctrl(input string tag);
        chk({tag, ".regsel"}, {13'd0, RegSel}, 16'h0007);
        chk({tag, ".memreq"}, {15'd0, MemReq}, 16'h0000);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] data);
        CmdOp    = op;
        CmdData  = data;
        CmdValid = 1'b1;
        tick();
        CmdValid = 1'b0;
        CmdData  = 16'h0000;
    endtask

    initial begin
        Reset    = 1'b1;
        CmdValid = 1'b0;
        CmdOp    = 3'b000;
        CmdData  = 16'h0000;
        PcIn     = 16'h0000;
        MemRData = 16'h0000;
        MemAck   = 1'b0;
`ifdef ARF_SEQ_STACK_CHECK_EN
        SpIn     = 16'h0100;
`endif
        tick();
        tick();
        Reset = 1'b0;

        // ---- reset values
        chk("rst.cmdready", {15'd0, CmdReady}, 16'h0001);
        chk("rst.regsel",   {13'd0, RegSel},   16'h0007);
        chk("rst.funsel",   {13'd0, FunSel},   16'h0000);
        chk("rst.outcsel",  {14'd0, OutCSel},  16'h0000);
        chk("rst.outdsel",  {14'd0, OutDSel},  16'h0000);
        chk("rst.arfi",     ArfI,              16'h0000);
        chk("rst.memreq",   {15'd0, MemReq},   16'h0000);
        chk("rst.memwrite", {15'd0, MemWrite}, 16'h0000);
        chk("rst.memwdata", MemWData,          16'h0000);
        chk("rst.rspvalid", {15'd0, RspValid}, 16'h0000);
        chk("rst.rspdata",  RspData,           16'h0000);
        chk("rst.rsperr",   {15'd0, RspErr},   16'h0000);

        // ---- FETCH, zero-wait ack, PC=0x0010
        PcIn = 16'h0010;
        issue(3'b001, 16'h0000);
        chk("fetch.mem.req",     {15'd0, MemReq},   16'h0001);
        chk("fetch.mem.write",   {15'd0, MemWrite}, 16'h0000);
        chk("fetch.mem.outdsel", {14'd0, OutDSel},  16'h0000);
        chk("fetch.mem.regsel",  {13'd0, RegSel},   16'h0007);
        chk("fetch.mem.ready",   {15'd0, CmdReady}, 16'h0000);
        MemAck = 1'b1; MemRData = 16'hABCD;
        tick();
        MemAck = 1'b0; MemRData = 16'h0000;
        chk("fetch.inc.funsel", {13'd0, FunSel}, 16'h0001);
        chk("fetch.inc.regsel", {13'd0, RegSel}, 16'h0003);
        chk("fetch.inc.memreq", {15'd0, MemReq}, 16'h0000);
        chk("fetch.inc.rspv",   {15'd0, RspValid}, 16'h0000);
        tick();
        chk("fetch.rsp.valid",  {15'd0, RspValid}, 16'h0001);
        chk("fetch.rsp.data",   RspData,           16'hABCD);
        chk("fetch.rsp.err",    {15'd0, RspErr},   16'h0000);
        chk("fetch.rsp.regsel", {13'd0, RegSel},   16'h0007);
        chk("fetch.rsp.ready",  {15'd0, CmdReady}, 16'h0000);
        tick();
        chk("fetch.done.valid", {15'd0, RspValid}, 16'h0000);
        chk("fetch.done.ready", {15'd0, CmdReady}, 16'h0001);

        // ---- NOP: one-cycle latency
        issue(3'b000, 16'h0000);
        chk("nop.rsp.valid", {15'd0, RspValid}, 16'h0001);
        chk("nop.rsp.err",   {15'd0, RspErr},   16'h0000);
        chk_idle_ctrl("nop.rsp");
        tick();
        chk("nop.done.ready", {15'd0, CmdReady}, 16'h0001);

        // ---- JUMP 0x1111: LOAD_PC then RSP
        issue(3'b100, 16'h1111);
        chk("jump.ld.funsel", {13'd0, FunSel}, 16'h0002);
        chk("jump.ld.regsel", {13'd0, RegSel}, 16'h0003);
        chk("jump.ld.arfi",   ArfI,            16'h1111);
        tick();
        chk("jump.rsp.valid", {15'd0, RspValid}, 16'h0001);
        chk_idle_ctrl("jump.rsp");
        tick();

        // ---- PUSH 0x1234 (CmdData cleared after accept to show it is latched)
        issue(3'b010, 16'h1234);
        chk("push.dec.funsel", {13'd0, FunSel}, 16'h0000);
        chk("push.dec.regsel", {13'd0, RegSel}, 16'h0006);
        chk("push.dec.memreq", {15'd0, MemReq}, 16'h0000);
        tick();
        chk("push.mem.req",     {15'd0, MemReq},   16'h0001);
        chk("push.mem.write",   {15'd0, MemWrite}, 16'h0001);
        chk("push.mem.outdsel", {14'd0, OutDSel},  16'h0003);
        chk("push.mem.wdata",   MemWData,          16'h1234);
        chk("push.mem.regsel",  {13'd0, RegSel},   16'h0007);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk("push.rsp.valid", {15'd0, RspValid}, 16'h0001);
        chk("push.rsp.err",   {15'd0, RspErr},   16'h0000);
        chk_idle_ctrl("push.rsp");
        tick();

        // ---- POP, ack after 3 wait cycles (one short of TIMEOUT)
        issue(3'b011, 16'h0000);
        chk("pop.mem.req",     {15'd0, MemReq},   16'h0001);
        chk("pop.mem.write",   {15'd0, MemWrite}, 16'h0000);
        chk("pop.mem.outdsel", {14'd0, OutDSel},  16'h0003);
        tick();
        chk("pop.wait1.req", {15'd0, MemReq}, 16'h0001);
        tick();
        chk("pop.wait2.req", {15'd0, MemReq}, 16'h0001);
        tick();
        chk("pop.wait3.req", {15'd0, MemReq}, 16'h0001);
        MemAck = 1'b1; MemRData = 16'h1234;
        tick();
        MemAck = 1'b0; MemRData = 16'h0000;
        chk("pop.inc.funsel", {13'd0, FunSel}, 16'h0001);
        chk("pop.inc.regsel", {13'd0, RegSel}, 16'h0006);
        chk("pop.inc.memreq", {15'd0, MemReq}, 16'h0000);
        tick();
        chk("pop.rsp.valid", {15'd0, RspValid}, 16'h0001);
        chk("pop.rsp.data",  RspData,           16'h1234);
        chk("pop.rsp.err",   {15'd0, RspErr},   16'h0000);
        tick();

        // ---- CALL 0x0400 with PC=0x0020 (PcIn changed after accept)
        PcIn = 16'h0020;
        issue(3'b101, 16'h0400);
        PcIn = 16'h9999;
        chk("call.dec.regsel", {13'd0, RegSel}, 16'h0006);
        tick();
        chk("call.mem.write",   {15'd0, MemWrite}, 16'h0001);
        chk("call.mem.outdsel", {14'd0, OutDSel},  16'h0003);
        chk("call.mem.wdata",   MemWData,          16'h0020);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        chk("call.ld.funsel", {13'd0, FunSel}, 16'h0002);
        chk("call.ld.regsel", {13'd0, RegSel}, 16'h0003);
        chk("call.ld.arfi",   ArfI,            16'h0400);
        tick();
        chk("call.rsp.valid", {15'd0, RspValid}, 16'h0001);
        chk_idle_ctrl("call.rsp");
        tick();

        // ---- RET: pop 0x0020 into PC
        issue(3'b110, 16'h0000);
        chk("ret.mem.write",   {15'd0, MemWrite}, 16'h0000);
        chk("ret.mem.outdsel", {14'd0, OutDSel},  16'h0003);
        MemAck = 1'b1; MemRData = 16'h0020;
        tick();
        MemAck = 1'b0; MemRData = 16'h0000;
        chk("ret.inc.funsel", {13'd0, FunSel}, 16'h0001);
        chk("ret.inc.regsel", {13'd0, RegSel}, 16'h0006);
        tick();
        chk("ret.ld.funsel", {13'd0, FunSel}, 16'h0002);
        chk("ret.ld.regsel", {13'd0, RegSel}, 16'h0003);
        chk("ret.ld.arfi",   ArfI,            16'h0020);
        tick();
        chk("ret.rsp.valid", {15'd0, RspValid}, 16'h0001);
        chk("ret.rsp.data",  RspData,           16'h0020);
        tick();

        // ---- FETCH timeout: ack never comes, MemReq high for 4 cycles
        issue(3'b001, 16'h0000);
        chk("to.c1.req", {15'd0, MemReq}, 16'h0001);
        tick();
        chk("to.c2.req", {15'd0, MemReq}, 16'h0001);
        tick();
        chk("to.c3.req", {15'd0, MemReq}, 16'h0001);
        tick();
        chk("to.c4.req", {15'd0, MemReq}, 16'h0001);
        tick();
        chk("to.rsp.valid", {15'd0, RspValid}, 16'h0001);
        chk("to.rsp.err",   {15'd0, RspErr},   16'h0001);
        chk_idle_ctrl("to.rsp");
        tick();
        chk("to.done.valid", {15'd0, RspValid}, 16'h0000);
        chk("to.done.regsel", {13'd0, RegSel},  16'h0007);
        chk("to.done.ready", {15'd0, CmdReady}, 16'h0001);

        // ---- reset held 2 cycles while FETCH sits in MEM
        issue(3'b001, 16'h0000);
        chk("rmid.mem.req", {15'd0, MemReq}, 16'h0001);
        Reset = 1'b1;
        tick();
        chk_idle_ctrl("rmid.r1");
        chk("rmid.r1.ready", {15'd0, CmdReady}, 16'h0001);
        chk("rmid.r1.valid", {15'd0, RspValid}, 16'h0000);
        tick();
        Reset = 1'b0;
        tick();
        chk_idle_ctrl("rmid.after");
        chk("rmid.after.valid", {15'd0, RspValid}, 16'h0000);
        chk("rmid.after.ready", {15'd0, CmdReady}, 16'h0001);

`ifdef ARF_SEQ_STACK_CHECK_EN
        // ---- stack faults: PUSH at bottom, POP at top
        SpIn = 16'hFF00;
        issue(3'b010, 16'h5555);
        chk("sf.push.valid", {15'd0, RspValid}, 16'h0001);
        chk("sf.push.err",   {15'd0, RspErr},   16'h0001);
        chk_idle_ctrl("sf.push");
        tick();
        SpIn = 16'hFFFF;
        issue(3'b011, 16'h0000);
        chk("sf.pop.valid", {15'd0, RspValid}, 16'h0001);
        chk("sf.pop.err",   {15'd0, RspErr},   16'h0001);
        chk_idle_ctrl("sf.pop");
        tick();
        SpIn = 16'h0100;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
